// File: rtl/bus6_rr_arbiter_pkg.sv
// Shared types and constants for the six-source round-robin bus arbiter.
package bus6_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Requester indices, bit position in req/gnt.
    localparam logic [2:0] REQ_A = 3'd0;
    localparam logic [2:0] REQ_B = 3'd1;
    localparam logic [2:0] REQ_C = 3'd2;
    localparam logic [2:0] REQ_D = 3'd3;
    localparam logic [2:0] REQ_E = 3'd4;
    localparam logic [2:0] REQ_F = 3'd5;

    // Mux select patterns {s1,s2,s3,s4,s5}; don't-care bits forced to 0.
    localparam logic [4:0] SEL_A = 5'b10000;
    localparam logic [4:0] SEL_B = 5'b01100;
    localparam logic [4:0] SEL_C = 5'b01000;
    localparam logic [4:0] SEL_D = 5'b00010;
    localparam logic [4:0] SEL_E = 5'b00001;
    localparam logic [4:0] SEL_F = 5'b00000;

    function automatic logic [4:0] sel_of(input logic [2:0] idx);
        case (idx)
            REQ_A:   sel_of = SEL_A;
            REQ_B:   sel_of = SEL_B;
            REQ_C:   sel_of = SEL_C;
            REQ_D:   sel_of = SEL_D;
            REQ_E:   sel_of = SEL_E;
            default: sel_of = SEL_F;
        endcase
    endfunction

    // Next requester index, wrapping 5 -> 0.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        next_idx = (idx >= REQ_F) ? REQ_A : idx + 3'd1;
    endfunction

endpackage

// File: rtl/bus6_rr_arbiter_rr_pick6.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, .. mod 6.
module rr_pick6
    import bus6_rr_arbiter_pkg::*;
(
    input  logic [5:0] req,
    input  logic [2:0] ptr,
    output logic       any,
    output logic [2:0] idx
);

    logic [7:0] req8;

    assign req8 = {2'b00, req};

    // Walk six candidates starting at ptr; keep the first one requesting.
    always_comb begin
        logic       found;
        logic [2:0] cand;
        any   = |req;
        idx   = REQ_A;
        found = 1'b0;
        cand  = ptr;
        for (int i = 0; i < 6; i++) begin
            if (!found && req8[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
            cand = next_idx(cand);
        end
    end

endmodule

// File: rtl/bus6_rr_arbiter.sv
// Six-requester round-robin arbiter driving a priority select mux.
// Handshake: a requester raises req and holds it while it owns the bus; gnt
// (one-hot, registered) names the owner one cycle later. The owner drops req
// to release, or loses the bus after MAX_HOLD grant cycles. Every release is
// followed by exactly one gnt=0 cycle before the next grant.
module bus6_rr_arbiter
    import bus6_rr_arbiter_pkg::*;
#(
    parameter int DW       = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    req,
    input  logic [DW-1:0] din_a,
    input  logic [DW-1:0] din_b,
    input  logic [DW-1:0] din_c,
    input  logic [DW-1:0] din_d,
    input  logic [DW-1:0] din_e,
    input  logic [DW-1:0] din_f,
    output logic [5:0]    gnt,
    output logic          sel1,
    output logic          sel2,
    output logic          sel3,
    output logic          sel4,
    output logic          sel5,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam int            HW        = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    owner_q, owner_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [5:0]    gnt_q, gnt_d;
    logic [4:0]    sel_q, sel_d;
    logic [DW-1:0] dout_q, dmux;
    logic          vld_q;
    logic          pick_any;
    logic [2:0]    pick_idx;
    logic [7:0]    req8;
    logic          release_now;

    assign req8 = {2'b00, req};

    rr_pick6 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Owner drop and timeout collapse into a single release.
    assign release_now = (state_q == ST_GRANT) &&
                         (!req8[owner_q] || (hold_q == HOLD_LAST));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_any) state_d = ST_GRANT;
            ST_GRANT: if (release_now) state_d = ST_GAP;
            ST_GAP:   state_d = pick_any ? ST_GRANT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of grant, select, pointer and hold counter.
    always_comb begin
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ST_GRANT: begin
                if (release_now) begin
                    gnt_d  = '0;
                    sel_d  = '0;
                    hold_d = '0;
                    ptr_d  = next_idx(owner_q);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    gnt_d   = 6'b000001 << pick_idx;
                    sel_d   = sel_of(pick_idx);
                    hold_d  = '0;
                end else begin
                    gnt_d = '0;
                    sel_d = '0;
                end
            end
        endcase
    end

    // Priority select mux, decoded from the registered select lines.
    always_comb begin
        casez (sel_q)
            5'b1????: dmux = din_a;
            5'b011??: dmux = din_b;
            5'b010??: dmux = din_c;
            5'b00?1?: dmux = din_d;
            5'b00?01: dmux = din_e;
            default:  dmux = din_f;
        endcase
    end

    // Output and bookkeeping registers; reset wins even mid-grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q   <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
            ptr_q   <= REQ_A;
            owner_q <= REQ_A;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            dout_q  <= dmux;
            vld_q   <= (state_q == ST_GRANT);
        end
    end

    assign gnt       = gnt_q;
    assign sel1      = sel_q[4];
    assign sel2      = sel_q[3];
    assign sel3      = sel_q[2];
    assign sel4      = sel_q[1];
    assign sel5      = sel_q[0];
    assign dout      = dout_q;
    assign dout_vld  = vld_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus6_rr_arbiter.sv
// Directed bench for bus6_rr_arbiter (DW=4, MAX_HOLD=8).
module tb_bus6_rr_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] req;
    logic [3:0] din [6];
    logic [5:0] gnt;
    logic       sel1, sel2, sel3, sel4, sel5;
    logic [3:0] dout;
    logic       dout_vld;
    logic       busy;
    logic [1:0] dbg_state;

    logic [4:0] exp_sel [6];
    int         seq [11];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    bus6_rr_arbiter #(.DW(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din_a     (din[0]),
        .din_b     (din[1]),
        .din_c     (din[2]),
        .din_d     (din[3]),
        .din_e     (din[4]),
        .din_f     (din[5]),
        .gnt       (gnt),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .sel4      (sel4),
        .sel5      (sel5),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    // All outputs at their reset values.
    task automatic reset_check(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 32'h0);
        chk({tag, "_sel"},  32'({sel1, sel2, sel3, sel4, sel5}), 32'h0);
        chk({tag, "_dout"}, 32'(dout), 32'h0);
        chk({tag, "_vld"},  32'(dout_vld), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_st"},   32'(dbg_state), 32'(S_IDLE));
    endtask

    // n grant cycles for owner; data valid from the second one.
    task automatic grant_run(input int owner, input int n);
        logic [5:0] oh;
        oh = 6'b000001 << owner;
        for (int k = 0; k < n; k++) begin
            edge_wait();
            chk($sformatf("gnt_o%0d_c%0d", owner, k), 32'(gnt), 32'(oh));
            chk($sformatf("sel_o%0d_c%0d", owner, k), 32'({sel1, sel2, sel3, sel4, sel5}), 32'(exp_sel[owner]));
            chk($sformatf("busy_o%0d_c%0d", owner, k), 32'(busy), 32'h1);
            chk($sformatf("st_o%0d_c%0d", owner, k), 32'(dbg_state), 32'(S_GRANT));
            if (k == 0) begin
                chk($sformatf("vld_o%0d_c0", owner), 32'(dout_vld), 32'h0);
            end else begin
                chk($sformatf("vld_o%0d_c%0d", owner, k), 32'(dout_vld), 32'h1);
                chk($sformatf("dout_o%0d_c%0d", owner, k), 32'(dout), 32'(din[owner]));
            end
        end
    endtask

    // One gap cycle after owner released; last owner data still on dout.
    task automatic gap_check(input int owner);
        edge_wait();
        chk($sformatf("gap_gnt_o%0d", owner), 32'(gnt), 32'h0);
        chk($sformatf("gap_sel_o%0d", owner), 32'({sel1, sel2, sel3, sel4, sel5}), 32'h0);
        chk($sformatf("gap_busy_o%0d", owner), 32'(busy), 32'h1);
        chk($sformatf("gap_st_o%0d", owner), 32'(dbg_state), 32'(S_GAP));
        chk($sformatf("gap_vld_o%0d", owner), 32'(dout_vld), 32'h1);
        chk($sformatf("gap_dout_o%0d", owner), 32'(dout), 32'(din[owner]));
    endtask

    task automatic idle_check(input string tag);
        edge_wait();
        chk({tag, "_gnt"},  32'(gnt), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_st"},   32'(dbg_state), 32'(S_IDLE));
        chk({tag, "_vld"},  32'(dout_vld), 32'h0);
    endtask

    initial begin
        exp_sel[0] = 5'b10000;
        exp_sel[1] = 5'b01100;
        exp_sel[2] = 5'b01000;
        exp_sel[3] = 5'b00010;
        exp_sel[4] = 5'b00001;
        exp_sel[5] = 5'b00000;
        seq = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4};
        din[0] = 4'h1; din[1] = 4'h2; din[2] = 4'h3;
        din[3] = 4'h4; din[4] = 4'h5; din[5] = 4'h6;

        // 1: reset held two cycles with every request up.
        rst = 1'b1;
        req = 6'h3F;
        edge_wait();
        edge_wait();
        reset_check("rst");
        rst = 1'b0;
        grant_run(0, 1);
        req = 6'h00;
        gap_check(0);
        idle_check("idle1");

        // 2: single requester c, released after cycle 4 (ptr is at b).
        din[2] = 4'h9;
        req = 6'b000100;
        grant_run(2, 4);
        req = 6'h00;
        gap_check(2);
        idle_check("idle2");

        // 3: full load from a fresh pointer, 8-cycle holds.
        rst = 1'b1;
        edge_wait();
        rst = 1'b0;
        req = 6'h3F;
        for (int i = 0; i < 11; i++) begin
            grant_run(seq[i], 8);
            gap_check(seq[i]);
        end

        // 4: wrap after e; requests changed during the gap are seen there.
        req = 6'b100001;
        grant_run(5, 8);
        gap_check(5);
        grant_run(0, 8);
        gap_check(0);
        req = 6'h00;
        idle_check("idle4");

        // 5: sole requester b keeps getting re-granted after each timeout.
        req = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            grant_run(1, 8);
            gap_check(1);
        end
        req = 6'h00;
        idle_check("idle5");

        // 6: reset in the middle of d's grant, then priority restarts at a.
        req = 6'b001000;
        grant_run(3, 3);
        rst = 1'b1;
        edge_wait();
        reset_check("midrst");
        rst = 1'b0;
        req = 6'h3F;
        grant_run(0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
